mmm_seq_90b: RTL and testbench

Sequencer for 90-bit Montgomery modular multiplication (MMM). It computes o_res = a·b·R⁻¹ mod N, with R = 2^90. It drives the team's external 5-stage pipelined 90×90→181-bit multiplier three times in sequence: T = a·b, m = T·N' mod R, P = m·N. It then forms U = (T+P)/R and applies the final conditional subtraction. The block sits between the modular-exponentiation control layer and the multiplier, and owns the multiplier's operand ports while busy.

---
 rtl/mmm_seq_90b_if.sv | 24 ++
 rtl/mmm_seq_90b.sv | 131 +++++++++++++
 tb/tb_mmm_seq_90b.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mmm_seq_90b_if.sv
// Operand/result bus between the Montgomery sequencer and the external
// pipelined 90x90->181-bit multiplier.
interface mmm_seq_90b_if #(
  parameter int NW = 90
);
  logic [NW-1:0] o_mul_a;
  logic [NW-1:0] o_mul_b;
  logic          o_mul_carry;
  logic [2*NW:0] i_mul_res;

  modport master (
    output o_mul_a,
    output o_mul_b,
    output o_mul_carry,
    input  i_mul_res
  );

  modport slave (
    input  o_mul_a,
    input  o_mul_b,
    input  o_mul_carry,
    output i_mul_res
  );
endinterface

// File: rtl/mmm_seq_90b.sv
// Montgomery modular multiplication sequencer: res = a*b*2^-NW mod N, using
// three passes through an external MUL_LAT-deep pipelined multiplier.
module mmm_seq_90b #(
  parameter int NW      = 90,
  parameter int MUL_LAT = 5
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_start,
  input  logic          i_clr,
  input  logic [NW-1:0] i_a,
  input  logic [NW-1:0] i_b,
  input  logic [NW-1:0] i_n,
  input  logic [NW-1:0] i_nprime,
  output logic          o_busy,
  output logic          o_done,
  output logic [NW-1:0] o_res,
  mmm_seq_90b_if.master mul
);

  typedef enum logic [3:0] {
    IDLE,
    ISS_T, WAIT_T, CAP_T,
    ISS_M, WAIT_M, CAP_M,
    ISS_U, WAIT_U, CAP_U,
    RED,
    DONE
  } state_t;

  // The wait counter runs MUL_LAT-2 .. 0, giving MUL_LAT-1 cycles per WAIT state.
  localparam int             CW       = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;
  localparam logic [CW-1:0]  CNT_LOAD = CW'(MUL_LAT - 2);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [NW-1:0]   a_r, b_r, n_r, np_r;
  logic [2*NW-1:0] t_r;
  logic [NW-1:0]   m_r;
  logic [NW:0]     u_r;

  logic [NW:0]     u_next;
  logic [NW-1:0]   u_minus_n;

  // NOTE: every clocked register uses non-blocking (<=) assignments so all
  // flops update together from pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: next-state and counter get their hold values first so no path through
  // this always_comb leaves them unassigned, which would infer latches.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (i_clr) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:   if (i_start) state_d = ISS_T;
        ISS_T:  begin state_d = WAIT_T; cnt_d = CNT_LOAD; end
        WAIT_T: if (cnt_q == '0) state_d = CAP_T; else cnt_d = cnt_q - 1'b1;
        CAP_T:  state_d = ISS_M;
        ISS_M:  begin state_d = WAIT_M; cnt_d = CNT_LOAD; end
        WAIT_M: if (cnt_q == '0) state_d = CAP_M; else cnt_d = cnt_q - 1'b1;
        CAP_M:  state_d = ISS_U;
        ISS_U:  begin state_d = WAIT_U; cnt_d = CNT_LOAD; end
        WAIT_U: if (cnt_q == '0) state_d = CAP_U; else cnt_d = cnt_q - 1'b1;
        CAP_U:  state_d = RED;
        RED:    state_d = DONE;
        DONE:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Operands are driven only while issuing, so the multiplier sees zeros otherwise.
  always_comb begin
    mul.o_mul_a = '0;
    mul.o_mul_b = '0;
    unique case (state_q)
      ISS_T:   begin mul.o_mul_a = a_r;          mul.o_mul_b = b_r;  end
      ISS_M:   begin mul.o_mul_a = t_r[NW-1:0];  mul.o_mul_b = np_r; end
      ISS_U:   begin mul.o_mul_a = m_r;          mul.o_mul_b = n_r;  end
      default: ;
    endcase
  end

  assign mul.o_mul_carry = 1'b0;

  // (T + m*N) is an exact multiple of R, so only the upper NW+1 bits are kept.
  assign u_next    = (NW+1)'(({1'b0, t_r} + mul.i_mul_res) >> NW);
  assign u_minus_n = NW'(u_r - {1'b0, n_r});

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      a_r   <= '0;
      b_r   <= '0;
      n_r   <= '0;
      np_r  <= '0;
      t_r   <= '0;
      m_r   <= '0;
      u_r   <= '0;
      o_res <= '0;
    end else if (!i_clr) begin
      unique case (state_q)
        IDLE: if (i_start) begin
          a_r  <= i_a;
          b_r  <= i_b;
          n_r  <= i_n;
          np_r <= i_nprime;
        end
        CAP_T: t_r <= mul.i_mul_res[2*NW-1:0];
        CAP_M: m_r <= mul.i_mul_res[NW-1:0];
        CAP_U: u_r <= u_next;
        RED:   o_res <= (u_r >= {1'b0, n_r}) ? u_minus_n : u_r[NW-1:0];
        default: ;
      endcase
    end
  end

  assign o_busy = (state_q != IDLE);
  assign o_done = (state_q == DONE);

endmodule

// File: tb/tb_mmm_seq_90b.sv
// Self-checking bench for mmm_seq_90b with a behavioural pipelined multiplier
// and a bit-serial reference for a*b*2^-NW mod N.
module tb_mmm_seq_90b;

  localparam int NW      = 90;
  localparam int MUL_LAT = 5;
  localparam int W       = 2*NW + 1;
  localparam int WX      = 2*NW + 2;
  localparam int DONE_K  = 3*MUL_LAT + 4;
  localparam int BUSY_N  = 3*MUL_LAT + 5;
  localparam int N_RAND  = 1500;

  typedef logic [W-1:0] val_t;

  localparam logic [NW-1:0] N_T    = {1'b1, 88'b0, 1'b1};   // 2^89 + 1
  localparam logic [NW-1:0] NP_T   = {1'b0, {89{1'b1}}};    // 2^89 - 1
  localparam logic [NW-1:0] NM1_T  = {1'b1, 89'b0};         // 2^89 = N - 1
  localparam logic [NW-1:0] RINV_T = {2'b01, 88'b0};        // 2^88
  localparam logic [NW-1:0] MASK89 = {1'b0, {89{1'b1}}};

  logic          clk;
  logic          rstn;
  logic          start;
  logic          clr;
  logic [NW-1:0] a_in, b_in, n_in, np_in;
  logic          busy, done;
  logic [NW-1:0] res;

  int n_tests = 0;
  int n_fail  = 0;

  mmm_seq_90b_if #(.NW(NW)) mul_if ();

  mmm_seq_90b #(.NW(NW), .MUL_LAT(MUL_LAT)) dut (
    .i_clk    (clk),
    .i_rstn   (rstn),
    .i_start  (start),
    .i_clr    (clr),
    .i_a      (a_in),
    .i_b      (b_in),
    .i_n      (n_in),
    .i_nprime (np_in),
    .o_busy   (busy),
    .o_done   (done),
    .o_res    (res),
    .mul      (mul_if)
  );

  // External multiplier: samples operands every edge, result MUL_LAT edges later.
  val_t pipe [MUL_LAT];
  always @(posedge clk) begin
    pipe[0] <= val_t'(mul_if.o_mul_a) * val_t'(mul_if.o_mul_b);
    for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mul_if.i_mul_res = pipe[MUL_LAT-1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input val_t act, input val_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [NW-1:0] rand_nw();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[NW-1:0];
  endfunction

  // N' = -N^-1 mod 2^NW by Newton iteration (precision doubles each step).
  function automatic logic [NW-1:0] calc_nprime(input logic [NW-1:0] n);
    logic [NW-1:0] x;
    x = n;
    for (int i = 0; i < 6; i++) x = x * (NW'(2) - n * x);
    return NW'(0) - x;
  endfunction

  // a*b*2^-NW mod N: reduce the product, then halve mod N NW times.
  function automatic logic [NW-1:0] mont_ref(input logic [NW-1:0] a, b, n);
    logic [WX-1:0] x, nn;
    nn = WX'(n);
    x  = (WX'(a) * WX'(b)) % nn;
    for (int i = 0; i < NW; i++) x = x[0] ? ((x + nn) >> 1) : (x >> 1);
    return x[NW-1:0];
  endfunction

  // One full operation: start, watch every cycle, then check result and timing.
  task automatic run_op(input string tag, input logic [NW-1:0] a, b, n, np,
                        input logic [NW-1:0] exp, input bit poke);
    int  done_k, dones, busy_cyc, bad_mux;
    bit  iss;
    @(negedge clk);
    a_in = a; b_in = b; n_in = n; np_in = np; clr = 1'b0; start = 1'b1;
    @(posedge clk);
    done_k = -1; dones = 0; busy_cyc = 0; bad_mux = 0;
    for (int k = 0; k <= DONE_K + 8; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 0) begin
        a_in = ~a; b_in = ~b; n_in = ~n; np_in = ~np;
      end
      if (poke && (k == 5 || k == DONE_K)) start = 1'b1;
      if (busy) busy_cyc++;
      if (done) begin
        dones++;
        if (done_k < 0) done_k = k;
      end
      iss = (k % (MUL_LAT + 1) == 0) && (k < 3 * (MUL_LAT + 1));
      if (k == 0) begin
        if (mul_if.o_mul_a !== a || mul_if.o_mul_b !== b) bad_mux++;
      end else if (!iss && (mul_if.o_mul_a !== '0 || mul_if.o_mul_b !== '0)) begin
        bad_mux++;
      end
      if (mul_if.o_mul_carry !== 1'b0) bad_mux++;
      if (done_k >= 0 && k == done_k + 1) break;
      @(posedge clk);
    end
    start = 1'b0;
    check({tag, ".res"},       val_t'(res),      val_t'(exp));
    check({tag, ".done_edge"}, val_t'(done_k),   val_t'(DONE_K));
    check({tag, ".done_cnt"},  val_t'(dones),    val_t'(1));
    check({tag, ".busy_cyc"},  val_t'(busy_cyc), val_t'(BUSY_N));
    check({tag, ".mux"},       val_t'(bad_mux),  val_t'(0));
  endtask

  initial begin
    logic [NW-1:0] a, b, n, np;
    int dones, busy_cyc;

    rstn = 1'b0; start = 1'b0; clr = 1'b0;
    a_in = '0; b_in = '0; n_in = '0; np_in = '0;
    repeat (3) @(negedge clk);
    check("rst.busy",  val_t'(busy), val_t'(0));
    check("rst.done",  val_t'(done), val_t'(0));
    check("rst.res",   val_t'(res),  val_t'(0));
    check("rst.mul_a", val_t'(mul_if.o_mul_a), val_t'(0));
    check("rst.mul_b", val_t'(mul_if.o_mul_b), val_t'(0));
    check("rst.carry", val_t'(mul_if.o_mul_carry), val_t'(0));
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst.busy", val_t'(busy), val_t'(0));

    run_op("basic",    NP_T,  90'd5,     N_T, NP_T, 90'd5,  1'b0);
    run_op("identity", 90'd1, 90'd1,     N_T, NP_T, RINV_T, 1'b0);
    run_op("boundary", NM1_T, NM1_T,     N_T, NP_T, RINV_T, 1'b0);
    run_op("zero",     90'd0, 90'd12345, N_T, NP_T, 90'd0,  1'b0);
    run_op("poke",     NP_T,  90'd5,     N_T, NP_T, 90'd5,  1'b1);

    // Abort at E8, then restart on the very next edge.
    @(negedge clk);
    a_in = 90'd3; b_in = 90'd7; n_in = N_T; np_in = NP_T; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k < 8; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    clr = 1'b1;
    @(posedge clk);
    #1;
    check("clr.busy", val_t'(busy), val_t'(0));
    check("clr.done", val_t'(done), val_t'(0));
    check("clr.res",  val_t'(res),  val_t'(5));
    run_op("restart", 90'd1, 90'd1, N_T, NP_T, RINV_T, 1'b0);

    // Simultaneous start and clear in IDLE must not start.
    @(negedge clk);
    start = 1'b1; clr = 1'b1;
    @(posedge clk);
    #1;
    check("clr_start.busy", val_t'(busy), val_t'(0));
    @(negedge clk);
    start = 1'b0; clr = 1'b0;
    check("clr_start.busy2", val_t'(busy), val_t'(0));

    // Reset asserted just after E10 of an operation.
    @(negedge clk);
    a_in = NP_T; b_in = 90'd5; n_in = N_T; np_in = NP_T; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst.busy",  val_t'(busy), val_t'(0));
    check("mid_rst.done",  val_t'(done), val_t'(0));
    check("mid_rst.res",   val_t'(res),  val_t'(0));
    check("mid_rst.mul_a", val_t'(mul_if.o_mul_a), val_t'(0));
    check("mid_rst.mul_b", val_t'(mul_if.o_mul_b), val_t'(0));
    @(negedge clk);
    rstn = 1'b1;
    dones = 0; busy_cyc = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done) dones++;
      if (busy) busy_cyc++;
    end
    check("mid_rst.no_done", val_t'(dones),    val_t'(0));
    check("mid_rst.idle",    val_t'(busy_cyc), val_t'(0));

    for (int i = 0; i < N_RAND; i++) begin
      n = (rand_nw() & MASK89) | 90'd1;
      if (n < 90'd3) n = 90'd3;
      np = calc_nprime(n);
      if (i % 8 == 0) begin
        a = n - 90'd1;
        b = n - 90'd1;
      end else begin
        a = rand_nw() % n;
        b = rand_nw() % n;
      end
      run_op($sformatf("rand%0d", i), a, b, n, np, mont_ref(a, b, n), (i % 50) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
